// File: rtl/aes_word_stream_adapter.sv
// Word-serial front/back end for an AES-128 core: gathers key and plaintext beats,
// pulses the core start, then streams the ciphertext back out MSW first.
module aes_word_stream_adapter #(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_key_hold,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic [127:0]      core_datain,
  output logic [127:0]      core_key,
  output logic              core_enable,
  input  logic [127:0]      core_dataout,
  input  logic              core_done,
  output logic              busy,
  output logic              timeout
);
  localparam int BEATS = 128 / WORD_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD_KEY  = 2'd0,
    ST_LOAD_DATA = 2'd1,
    ST_RUN       = 2'd2,
    ST_DRAIN     = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic             r_active, r_key_valid, r_first_run;
  logic [CNT_W-1:0] r_cnt;
  logic [WD_W-1:0]  r_wd;
  logic [127:0]     r_key, r_data, r_result;
  logic             w_s_fire, w_m_fire, w_reuse_key, w_capture, w_last_beat;

  function automatic logic [127:0] shift_in(input logic [127:0] blk,
                                            input logic [WORD_W-1:0] word);
    return {blk[127-WORD_W:0], word};
  endfunction

  assign w_last_beat = (r_cnt == LAST_BEAT);
  assign w_s_fire    = s_valid & s_ready;
  assign w_m_fire    = m_valid & m_ready;
  assign m_data      = m_valid ? r_result[127 -: WORD_W] : '0;
  assign m_last      = m_valid & w_last_beat;
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign core_key    = r_key;
  assign core_datain = r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_LOAD_KEY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    core_enable = 1'b0;
    timeout     = 1'b0;
    w_reuse_key = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_LOAD_KEY: begin
        // s_ready stays low until the first clock after reset release
        s_ready     = r_active;
        w_reuse_key = (r_cnt == '0) && s_key_hold && r_key_valid;
        if (s_valid && r_active && (w_reuse_key || w_last_beat)) w_next = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        s_ready = 1'b1;
        if (s_valid && w_last_beat) w_next = ST_RUN;
      end
      ST_RUN: begin
        core_enable = r_first_run;
        if (!r_first_run) begin
          if (core_done) begin
            w_capture = 1'b1;
            w_next    = ST_DRAIN;
          end else if (r_wd == WD_LAST) begin
            timeout = 1'b1;
            w_next  = ST_LOAD_KEY;
          end
        end
      end
      ST_DRAIN: begin
        m_valid = 1'b1;
        if (m_ready && w_last_beat) w_next = ST_LOAD_KEY;
      end
      default: w_next = ST_LOAD_KEY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_key_valid <= 1'b0;
      r_first_run <= 1'b0;
      r_cnt       <= '0;
      r_wd        <= '0;
      r_key       <= '0;
      r_data      <= '0;
      r_result    <= '0;
    end else begin
      r_active <= 1'b1;
      case (r_state)
        ST_LOAD_KEY: begin
          if (w_s_fire) begin
            if (w_reuse_key) begin
              r_data <= shift_in(r_data, s_data);
              r_cnt  <= CNT_W'(1);
            end else begin
              r_key <= shift_in(r_key, s_data);
              if (w_last_beat) begin
                r_cnt       <= '0;
                r_key_valid <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
        end
        ST_LOAD_DATA: begin
          if (w_s_fire) begin
            r_data <= shift_in(r_data, s_data);
            if (w_last_beat) begin
              r_cnt       <= '0;
              r_first_run <= 1'b1;
              r_wd        <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          r_first_run <= 1'b0;
          r_wd        <= r_wd + WD_W'(1);
          if (w_capture) r_result <= core_dataout;
        end
        ST_DRAIN: begin
          // result register shifts so the presented word is always the top slice
          if (w_m_fire) begin
            r_result <= r_result << WORD_W;
            r_cnt    <= w_last_beat ? '0 : r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_word_stream_adapter.sv
// Bench for aes_word_stream_adapter: transaction-level frame model, AES core stand-in
// with configurable done behaviour, randomised valid/ready gaps and mid-operation resets.
module tb_aes_word_stream_adapter;
  localparam int WORD_W  = 32;
  localparam int BEATS   = 128 / WORD_W;
  localparam int TIMEOUT = 64;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed { logic hold; logic [WORD_W-1:0] w; } beat_t;
  typedef struct packed { logic last; logic [WORD_W-1:0] w; } obeat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0, s_ready, s_key_hold = 1'b0;
  logic [WORD_W-1:0] s_data = '0;
  logic              m_valid, m_ready = 1'b0, m_last;
  logic [WORD_W-1:0] m_data;
  logic [127:0]      core_datain, core_key, core_dataout = '0;
  logic              core_enable, core_done = 1'b0, busy, timeout;

  aes_word_stream_adapter #(.WORD_W(WORD_W), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key_hold(s_key_hold),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core_datain(core_datain), .core_key(core_key), .core_enable(core_enable),
    .core_dataout(core_dataout), .core_done(core_done),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, vld_pct = 100, rdy_pct = 100;
  int core_mode = 0;   // 0: done after delay, 1: never done, 2: done held high
  int core_delay = 11; // 0 selects a random delay per block
  int core_cnt = -1;
  logic [127:0] core_result = '0;

  beat_t  in_q[$];
  obeat_t exp_q[$];
  bit kv = 0, in_frame = 0, key_mode = 0, pending_run = 0, ready_ok = 0, prev_stall = 0;
  int idx = 0, en_cycle = -1, n_to = 0, n_en = 0, n_blk = 0;
  logic [127:0] m_key = '0, kacc = '0, dacc = '0, exp_key = '0, exp_pt = '0, k, p;
  logic [WORD_W-1:0] prev_mdata = '0;
  bit reached;

  function automatic logic [127:0] core_fn(input logic [127:0] key, input logic [127:0] pt);
    if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
    return (pt ^ {key[63:0], key[127:64]}) + 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_frame(input bit hold, input bit send_key,
                            input logic [127:0] key, input logic [127:0] pt);
    beat_t b;
    if (send_key) begin
      for (int i = 0; i < BEATS; i++) begin
        b.hold = (i == 0) ? hold : 1'($urandom);
        b.w    = key[127 - WORD_W*i -: WORD_W];
        in_q.push_back(b);
      end
    end
    for (int i = 0; i < BEATS; i++) begin
      b.hold = (i == 0 && !send_key) ? hold : 1'($urandom);
      b.w    = pt[127 - WORD_W*i -: WORD_W];
      in_q.push_back(b);
    end
  endtask

  // Frame interpretation: the first beat decides key+data or data-only
  task automatic model_feed(input logic hold, input logic [WORD_W-1:0] w);
    if (!in_frame) begin
      in_frame = 1;
      idx      = 0;
      key_mode = !(hold && kv);
    end
    if (key_mode) begin
      kacc[127 - WORD_W*idx -: WORD_W] = w;
      idx++;
      if (idx == BEATS) begin
        m_key = kacc; kv = 1; key_mode = 0; idx = 0;
      end
    end else begin
      dacc[127 - WORD_W*idx -: WORD_W] = w;
      idx++;
      if (idx == BEATS) begin
        in_frame = 0; pending_run = 1; en_cycle = cyc + 1;
        exp_key = m_key; exp_pt = dacc; n_blk++;
      end
    end
  endtask

  task automatic check_and_update();
    bit busy_e, mv_e, to_e;
    beat_t hb;
    obeat_t ob;
    logic [127:0] ct;
    busy_e = pending_run || (exp_q.size() > 0);
    mv_e   = (exp_q.size() > 0) && !pending_run;
    to_e   = pending_run && (core_mode == 1) && (cyc == en_cycle + TIMEOUT - 1);
    check_bit("s_ready", s_ready, ready_ok && !busy_e);
    check_bit("m_valid", m_valid, mv_e);
    check_bit("busy", busy, busy_e);
    check_bit("core_enable", core_enable, cyc == en_cycle);
    check_bit("timeout", timeout, to_e);
    if (pending_run) begin
      check_vec("core_key", core_key, exp_key);
      check_vec("core_datain", core_datain, exp_pt);
    end
    if (mv_e) begin
      check_vec("m_data", 128'(m_data), 128'(exp_q[0].w));
      check_bit("m_last", m_last, exp_q[0].last);
    end
    if (prev_stall) check_vec("m_data_stall", 128'(m_data), 128'(prev_mdata));

    if (core_enable) begin
      n_en++;
      core_result = core_fn(core_key, core_datain);
      if (core_mode == 0)
        core_cnt = (core_delay > 0) ? core_delay : int'($urandom_range(40, 1));
    end
    if (cyc == en_cycle && core_mode != 1) begin
      ct = core_fn(exp_key, exp_pt);
      for (int i = 0; i < BEATS; i++) begin
        ob.w    = ct[127 - WORD_W*i -: WORD_W];
        ob.last = (i == BEATS - 1);
        exp_q.push_back(ob);
      end
    end
    if (pending_run && cyc > en_cycle && core_done) pending_run = 0;
    if (to_e) pending_run = 0;
    if (timeout) n_to++;
    prev_stall = mv_e && !m_ready;
    prev_mdata = m_data;
    if (mv_e && m_ready) void'(exp_q.pop_front());
    if (s_valid && ready_ok && !busy_e) begin
      hb = in_q.pop_front();
      model_feed(hb.hold, hb.w);
    end
  endtask

  task automatic cycle();
    beat_t hb;
    @(negedge clk);
    core_done = (core_mode == 2);
    if (core_mode == 0 && core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_cnt  = -1;
      end
    end
    core_dataout = core_result;
    if (in_q.size() > 0 && $urandom_range(99) < vld_pct) begin
      hb = in_q[0];
      s_valid = 1'b1; s_data = hb.w; s_key_hold = hb.hold;
    end else begin
      s_valid = 1'b0; s_data = $urandom; s_key_hold = 1'($urandom);
    end
    m_ready = ($urandom_range(99) < rdy_pct);
    #1;
    cyc++;
    check_and_update();
  endtask

  task automatic run_idle(input string tag, input int maxc);
    int n = 0;
    while ((in_q.size() > 0 || pending_run || exp_q.size() > 0) && n < maxc) begin
      cycle();
      n++;
    end
    check_bit(tag, (in_q.size() == 0) && !pending_run && (exp_q.size() == 0), 1'b1);
    repeat (2) cycle();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_bit({tag, "_s_ready"}, s_ready, 1'b0);
    check_bit({tag, "_m_valid"}, m_valid, 1'b0);
    check_bit({tag, "_m_last"}, m_last, 1'b0);
    check_bit({tag, "_core_enable"}, core_enable, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_timeout"}, timeout, 1'b0);
    check_vec({tag, "_m_data"}, 128'(m_data), '0);
    check_vec({tag, "_core_key"}, core_key, '0);
    check_vec({tag, "_core_datain"}, core_datain, '0);
    s_valid = 1'b0; m_ready = 1'b0; core_done = 1'b0; core_dataout = '0;
    in_q.delete(); exp_q.delete();
    kv = 0; in_frame = 0; pending_run = 0; ready_ok = 0; prev_stall = 0;
    en_cycle = -1; core_cnt = -1; core_result = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_bit({tag, "_s_ready_release"}, s_ready, 1'b0);
    ready_ok = 1;
  endtask

  initial begin
    do_reset("por");

    // Known-answer block; s_key_hold=1 with no stored key loads a key
    push_frame(1'b1, 1'b1, FIPS_KEY, FIPS_PT);
    run_idle("fips_idle", 300);

    // Stored key reused for a data-only frame
    p = {$urandom, $urandom, $urandom, $urandom};
    push_frame(1'b1, 1'b0, '0, p);
    run_idle("reuse_idle", 300);

    // 100 back-to-back random frames with 50% gaps on both sides
    vld_pct = 50; rdy_pct = 50; core_delay = 0;
    for (int i = 0; i < 100; i++) begin
      bit hold;
      hold = 1'($urandom);
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      push_frame(hold, !hold, k, p);
    end
    run_idle("random_idle", 20000);
    check_vec("random_enables", 128'(n_en), 128'(n_blk));

    // Core never finishes: watchdog abort, key retained afterwards
    vld_pct = 100; rdy_pct = 100; core_mode = 1; n_to = 0;
    p = {$urandom, $urandom, $urandom, $urandom};
    push_frame(1'b1, 1'b0, '0, p);
    run_idle("timeout_idle", 300);
    check_vec("timeout_count", 128'(n_to), 128'd1);
    core_mode = 0; core_delay = 11;
    p = {$urandom, $urandom, $urandom, $urandom};
    push_frame(1'b1, 1'b0, '0, p);
    run_idle("after_timeout_idle", 300);

    // core_done held high through the start cycle
    core_mode = 2;
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    push_frame(1'b0, 1'b1, k, p);
    push_frame(1'b1, 1'b0, '0, ~p);
    run_idle("early_done_idle", 300);
    check_vec("early_done_enables", 128'(n_en), 128'(n_blk));
    core_mode = 0;

    // Reset while loading data beat 2
    k = {$urandom, $urandom, $urandom, $urandom};
    push_frame(1'b0, 1'b1, k, p);
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      cycle();
      reached = in_frame && !key_mode && (idx == 2);
    end
    check_bit("reach_load_data_beat2", reached, 1'b1);
    do_reset("rst_ld2");

    // Reset while draining beat 1
    push_frame(1'b1, 1'b1, k, p);
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      cycle();
      reached = !pending_run && (exp_q.size() == BEATS - 1);
    end
    check_bit("reach_drain_beat1", reached, 1'b1);
    do_reset("rst_drain");

    // Fresh frame after the aborted ones
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    push_frame(1'b0, 1'b1, k, p);
    run_idle("fresh_idle", 300);
    check_vec("total_enables", 128'(n_en), 128'(n_blk));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
